// File: rtl/mem_result_scanner_pkg.sv
// rtl/mem_result_scanner_pkg.sv - shared widths, state encoding and sizing helpers for the result scanner
package mem_result_scanner_pkg;

    localparam int ADDR_W = 10;
    localparam int DISP_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRST  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FETCH = 3'd3,
        ST_SHOW  = 3'd4,
        ST_DONE  = 3'd5
    } scan_state_t;

    // A phase counter loaded with n-1 needs $clog2(n) bits; keep at least one bit for n==1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mem_result_scanner_cycle_down_counter.sv
// rtl/mem_result_scanner_cycle_down_counter.sv - loadable down counter that stops at zero and flags it
module mem_result_scanner_cycle_down_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_result_scanner.sv
// rtl/mem_result_scanner.sv - runs the core for a fixed window, then scans its data memory to the display
module mem_result_scanner
    import mem_result_scanner_pkg::*;
#(
    parameter int                RST_CYCLES  = 4,
    parameter int                RUN_CYCLES  = 1024,
    parameter logic [ADDR_W-1:0] ADDR_FIRST  = 10'd0,
    parameter logic [ADDR_W-1:0] ADDR_LAST   = 10'd15,
    parameter int                RD_LAT      = 2,
    parameter int                HOLD_CYCLES = 50000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_auto_mode,
    input  logic [DISP_W-1:0] i_proc_out,
    output logic              o_proc_rst,
    output logic              o_proc_sel,
    output logic [ADDR_W-1:0] o_proc_inp,
    output logic [DISP_W-1:0] o_disp_data,
    output logic [ADDR_W-1:0] o_disp_addr,
    output logic              o_disp_valid,
    output logic              o_busy,
    output logic              o_done
);

    localparam int PH_W = cnt_width(max3(RST_CYCLES, RUN_CYCLES, RD_LAT));
    localparam int DW_W = cnt_width(HOLD_CYCLES);
    localparam logic [PH_W-1:0] PH_PRST  = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_RUN   = PH_W'(RUN_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_FETCH = PH_W'(RD_LAT - 1);
    localparam logic [DW_W-1:0] DW_HOLD  = DW_W'(HOLD_CYCLES - 1);

    if (ADDR_LAST < ADDR_FIRST) begin : g_bad_range
        $error("mem_result_scanner: ADDR_LAST below ADDR_FIRST");
    end
    if (RST_CYCLES < 1 || RUN_CYCLES < 1 || RUN_CYCLES > 65535 || RD_LAT < 1 || HOLD_CYCLES < 1) begin : g_bad_count
        $error("mem_result_scanner: cycle parameter out of range");
    end

    scan_state_t       r_state;
    scan_state_t       w_state_nxt;
    logic              r_auto_prev;
    logic              r_proc_rst;
    logic              r_proc_sel;
    logic [ADDR_W-1:0] r_proc_inp;
    logic [DISP_W-1:0] r_disp_data;
    logic [ADDR_W-1:0] r_disp_addr;
    logic              r_disp_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_ph_zero;
    logic              w_dw_zero;
    logic              w_ph_load;
    logic [PH_W-1:0]   w_ph_val;
    logic              w_dw_load;
    logic              w_auto_chg;
    logic              w_adv;
    logic              w_capture;
    logic              w_valid_nxt;
    logic [ADDR_W-1:0] w_inp_nxt;

    // One counter times PRST, RUN and FETCH; it is reloaded on every phase entry.
    mem_result_scanner_cycle_down_counter #(.W(PH_W)) u_phase_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_ph_load),
        .i_load_val (w_ph_val),
        .i_en       (1'b1),
        .o_zero     (w_ph_zero)
    );

    mem_result_scanner_cycle_down_counter #(.W(DW_W)) u_dwell_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_dw_load),
        .i_load_val (DW_HOLD),
        .i_en       (r_state == ST_SHOW),
        .o_zero     (w_dw_zero)
    );

    assign w_auto_chg = (i_auto_mode != r_auto_prev);
    assign w_adv      = (r_state == ST_SHOW) &&
                        (i_auto_mode ? (!w_auto_chg && w_dw_zero) : i_step);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_auto_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_auto_prev <= i_auto_mode;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: if (i_start)   w_state_nxt = ST_PRST;
            ST_PRST:          if (w_ph_zero) w_state_nxt = ST_RUN;
            ST_RUN:           if (w_ph_zero) w_state_nxt = ST_FETCH;
            ST_FETCH:         if (w_ph_zero) w_state_nxt = ST_SHOW;
            ST_SHOW:          if (w_adv)     w_state_nxt = (r_proc_inp == ADDR_LAST) ? ST_DONE : ST_FETCH;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ph_load   = 1'b0;
        w_ph_val    = PH_PRST;
        w_dw_load   = 1'b0;
        w_capture   = 1'b0;
        w_valid_nxt = r_disp_valid;
        w_inp_nxt   = r_proc_inp;
        if (w_state_nxt != r_state) begin
            unique case (w_state_nxt)
                ST_PRST: begin
                    w_ph_load   = 1'b1;
                    w_ph_val    = PH_PRST;
                    w_valid_nxt = 1'b0;
                end
                ST_RUN: begin
                    w_ph_load = 1'b1;
                    w_ph_val  = PH_RUN;
                end
                ST_FETCH: begin
                    w_ph_load = 1'b1;
                    w_ph_val  = PH_FETCH;
                    w_inp_nxt = (r_state == ST_RUN) ? ADDR_FIRST : r_proc_inp + ADDR_W'(1);
                end
                ST_SHOW: begin
                    w_dw_load   = 1'b1;
                    w_capture   = 1'b1;
                    w_valid_nxt = 1'b1;
                end
                default: ;
            endcase
        end
        // Flipping auto_mode while showing restarts the dwell from the full hold time.
        if ((r_state == ST_SHOW) && (w_state_nxt == ST_SHOW) && w_auto_chg) begin
            w_dw_load = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_proc_rst   <= 1'b1;
            r_proc_sel   <= 1'b0;
            r_proc_inp   <= '0;
            r_disp_data  <= '0;
            r_disp_addr  <= '0;
            r_disp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_proc_rst   <= (w_state_nxt != ST_RUN);
            r_proc_sel   <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_SHOW) || (w_state_nxt == ST_DONE);
            r_proc_inp   <= w_inp_nxt;
            r_disp_valid <= w_valid_nxt;
            r_busy       <= (w_state_nxt == ST_PRST) || (w_state_nxt == ST_RUN) ||
                            (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_SHOW);
            r_done       <= (w_state_nxt == ST_DONE);
            if (w_capture) begin
                r_disp_data <= i_proc_out;
                r_disp_addr <= r_proc_inp;
            end
        end
    end

    assign o_proc_rst   = r_proc_rst;
    assign o_proc_sel   = r_proc_sel;
    assign o_proc_inp   = r_proc_inp;
    assign o_disp_data  = r_disp_data;
    assign o_disp_addr  = r_disp_addr;
    assign o_disp_valid = r_disp_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_mem_result_scanner.sv
// tb/tb_mem_result_scanner.sv - randomized self-checking bench for the memory result scanner
module tb_mem_result_scanner;

    localparam int          TB_RST   = 2;
    localparam int          TB_RUN   = 8;
    localparam logic [9:0]  TB_FIRST = 10'd0;
    localparam logic [9:0]  TB_LAST  = 10'd3;
    localparam int          TB_RDL   = 2;
    localparam int          TB_HOLD  = 5;

    logic        clk;
    logic        rst;
    logic        start;
    logic        step;
    logic        auto_mode;
    logic [15:0] proc_out;
    logic        proc_rst;
    logic        proc_sel;
    logic [9:0]  proc_inp;
    logic [15:0] disp_data;
    logic [9:0]  disp_addr;
    logic        disp_valid;
    logic        busy;
    logic        done;

    int total;
    int bad;

    logic [9:0] pipe [0:TB_RDL-1];

    mem_result_scanner #(
        .RST_CYCLES  (TB_RST),
        .RUN_CYCLES  (TB_RUN),
        .ADDR_FIRST  (TB_FIRST),
        .ADDR_LAST   (TB_LAST),
        .RD_LAT      (TB_RDL),
        .HOLD_CYCLES (TB_HOLD)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_step       (step),
        .i_auto_mode  (auto_mode),
        .i_proc_out   (proc_out),
        .o_proc_rst   (proc_rst),
        .o_proc_sel   (proc_sel),
        .o_proc_inp   (proc_inp),
        .o_disp_data  (disp_data),
        .o_disp_addr  (disp_addr),
        .o_disp_valid (disp_valid),
        .o_busy       (busy),
        .o_done       (done)
    );

    function automatic logic [15:0] mem_word(input logic [9:0] a);
        return {a, 6'b0} ^ 16'h00A5;
    endfunction

    // Memory model: read data reflects an address RD_LAT cycles after it was presented.
    always @(negedge clk) begin
        for (int i = TB_RDL - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = proc_inp;
    end
    assign proc_out = mem_word(pipe[TB_RDL-1]);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit);
        int guard;
        guard = 0;
        while (disp_valid !== 1'b1 && guard < limit) begin
            tick;
            guard++;
        end
    endtask

    task automatic measure(input bit noisy, output int n_hi, output int n_lo,
                           output logic sel_rise, output logic sel_low);
        int guard;
        guard = 0; n_hi = 0; n_lo = 0; sel_low = 1'b0;
        while (proc_rst === 1'b1 && guard < 100) begin
            n_hi++;
            if (noisy) start = 1'($urandom_range(0, 1));
            tick;
            guard++;
        end
        while (proc_rst === 1'b0 && guard < 100) begin
            n_lo++;
            if (proc_sel !== 1'b0) sel_low = 1'b1;
            if (noisy) start = 1'($urandom_range(0, 1));
            tick;
            guard++;
        end
        start = 1'b0;
        sel_rise = proc_sel;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 30; i++) begin
            start = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            auto_mode = 1'($urandom_range(0, 1));
            tick;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            auto_mode = 1'($urandom_range(0, 1));
            tick;
            total++; if (proc_rst !== 1'b1) begin bad++; $display("FAIL reset_proc_rst got=%b exp=1", proc_rst); end
            total++; if (proc_sel !== 1'b0) begin bad++; $display("FAIL reset_proc_sel got=%b exp=0", proc_sel); end
            total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL reset_disp_valid got=%b exp=0", disp_valid); end
            total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
            total++; if (proc_inp !== 10'd0) begin bad++; $display("FAIL reset_proc_inp got=%0d exp=0", proc_inp); end
        end
        rst = 1'b0; start = 1'b0; step = 1'b0; auto_mode = 1'b0;
        tick;
        total++; if (busy !== 1'b0 || proc_rst !== 1'b1) begin bad++; $display("FAIL reset_idle_hold got=busy%b rst%b exp=busy0 rst1", busy, proc_rst); end
    endtask

    task automatic test_run_window;
        int n_hi, n_lo;
        logic sel_rise, sel_low;
        start = 1'b1; tick; start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_busy got=%b exp=1", busy); end
        measure(1'b0, n_hi, n_lo, sel_rise, sel_low);
        total++; if (n_hi != TB_RST) begin bad++; $display("FAIL run_prst_len got=%0d exp=%0d", n_hi, TB_RST); end
        total++; if (n_lo != TB_RUN) begin bad++; $display("FAIL run_low_len got=%0d exp=%0d", n_lo, TB_RUN); end
        total++; if (sel_rise !== 1'b1) begin bad++; $display("FAIL run_sel_rise got=%b exp=1", sel_rise); end
        total++; if (sel_low !== 1'b0) begin bad++; $display("FAIL run_sel_low got=%b exp=0", sel_low); end
        total++; if (proc_inp !== TB_FIRST) begin bad++; $display("FAIL run_first_addr got=%0d exp=%0d", proc_inp, TB_FIRST); end
    endtask

    task automatic test_manual;
        logic [9:0] cur;
        auto_mode = 1'b0;
        wait_valid(20);
        total++;
        if (disp_valid !== 1'b1 || disp_addr !== TB_FIRST || disp_data !== mem_word(TB_FIRST)) begin
            bad++; $display("FAIL manual_first got=v%b a%0d d%h exp=v1 a%0d d%h", disp_valid, disp_addr, disp_data, TB_FIRST, mem_word(TB_FIRST));
        end
        cur = TB_FIRST;
        for (int n = 0; n <= int'(TB_LAST - TB_FIRST); n++) begin
            repeat ($urandom_range(0, 4)) tick;
            total++; if (disp_addr !== cur) begin bad++; $display("FAIL manual_hold got=%0d exp=%0d", disp_addr, cur); end
            step = 1'b1; tick; step = 1'b0;
            if (cur == TB_LAST) begin
                total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL manual_done got=done%b busy%b exp=done1 busy0", done, busy); end
                total++; if (disp_addr !== TB_LAST || disp_valid !== 1'b1 || proc_inp !== TB_LAST) begin
                    bad++; $display("FAIL manual_done_disp got=a%0d v%b inp%0d exp=a%0d v1 inp%0d", disp_addr, disp_valid, proc_inp, TB_LAST, TB_LAST);
                end
            end else begin
                for (int k = 1; k < TB_RDL; k++) begin
                    step = 1'($urandom_range(0, 1));
                    tick;
                    step = 1'b0;
                    total++; if (disp_addr !== cur) begin bad++; $display("FAIL manual_latency got=%0d exp=%0d", disp_addr, cur); end
                end
                tick;
                cur = cur + 10'd1;
                total++;
                if (disp_addr !== cur || disp_data !== mem_word(cur) || disp_valid !== 1'b1) begin
                    bad++; $display("FAIL manual_word got=a%0d d%h v%b exp=a%0d d%h v1", disp_addr, disp_data, disp_valid, cur, mem_word(cur));
                end
            end
        end
    endtask

    task automatic test_auto;
        int period, t_done;
        logic [9:0] ea;
        period = TB_RDL + TB_HOLD;
        t_done = int'(TB_LAST - TB_FIRST) * period + TB_HOLD;
        auto_mode = 1'b1; start = 1'b1; tick; start = 1'b0;
        total++; if (disp_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL auto_restart got=v%b busy%b exp=v0 busy1", disp_valid, busy); end
        begin
            int guard;
            guard = 0;
            while (disp_valid !== 1'b1 && guard < 100) begin
                step = 1'($urandom_range(0, 1));
                tick;
                guard++;
            end
        end
        total++; if (disp_valid !== 1'b1) begin bad++; $display("FAIL auto_first got=%b exp=1", disp_valid); end
        for (int t = 0; t < t_done; t++) begin
            ea = TB_FIRST + 10'(t / period);
            total++;
            if (disp_addr !== ea || disp_data !== mem_word(ea) || done !== 1'b0) begin
                bad++; $display("FAIL auto_scan t=%0d got=a%0d d%h done%b exp=a%0d d%h done0", t, disp_addr, disp_data, done, ea, mem_word(ea));
            end
            step = 1'($urandom_range(0, 1));
            tick;
        end
        step = 1'b0;
        total++; if (done !== 1'b1 || busy !== 1'b0 || disp_addr !== TB_LAST) begin
            bad++; $display("FAIL auto_done got=done%b busy%b a%0d exp=done1 busy0 a%0d", done, busy, disp_addr, TB_LAST);
        end
        auto_mode = 1'b0;
    endtask

    task automatic test_rst_in_show;
        auto_mode = 1'b0; start = 1'b1; tick; start = 1'b0;
        wait_valid(100);
        for (int n = 0; n < 2; n++) begin
            step = 1'b1; tick; step = 1'b0;
            repeat (TB_RDL) tick;
        end
        total++; if (disp_addr !== TB_FIRST + 10'd2) begin bad++; $display("FAIL rst_show_setup got=%0d exp=%0d", disp_addr, TB_FIRST + 10'd2); end
        repeat ($urandom_range(0, 3)) tick;
        rst = 1'b1; tick; rst = 1'b0;
        total++; if (proc_sel !== 1'b0 || proc_rst !== 1'b1) begin bad++; $display("FAIL rst_show_core got=sel%b rst%b exp=sel0 rst1", proc_sel, proc_rst); end
        total++; if (disp_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_show_flags got=v%b busy%b done%b exp=000", disp_valid, busy, done);
        end
        total++; if (proc_inp !== 10'd0) begin bad++; $display("FAIL rst_show_inp got=%0d exp=0", proc_inp); end
        start = 1'b1; tick; start = 1'b0;
        wait_valid(100);
        total++; if (disp_valid !== 1'b1 || disp_addr !== TB_FIRST || disp_data !== mem_word(TB_FIRST)) begin
            bad++; $display("FAIL rst_show_rescan got=v%b a%0d d%h exp=v1 a%0d d%h", disp_valid, disp_addr, disp_data, TB_FIRST, mem_word(TB_FIRST));
        end
    endtask

    task automatic test_start_ignored;
        int n_hi, n_lo;
        logic sel_rise, sel_low;
        start = 1'b1; step = 1'b1; tick; start = 1'b0; step = 1'b0;
        total++; if (busy !== 1'b1 || proc_rst !== 1'b1) begin bad++; $display("FAIL ign_show_start got=busy%b rst%b exp=busy1 rst1", busy, proc_rst); end
        repeat (TB_RDL) tick;
        total++; if (disp_addr !== TB_FIRST + 10'd1) begin bad++; $display("FAIL ign_step_wins got=%0d exp=%0d", disp_addr, TB_FIRST + 10'd1); end
        for (int a = int'(TB_FIRST) + 2; a <= int'(TB_LAST); a++) begin
            step = 1'b1; tick; step = 1'b0;
            repeat (TB_RDL) tick;
        end
        step = 1'b1; tick; step = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_reach_done got=%b exp=1", done); end
        start = 1'b1; tick; start = 1'b0;
        total++; if (disp_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL ign_done_restart got=v%b busy%b done%b exp=v0 busy1 done0", disp_valid, busy, done);
        end
        measure(1'b1, n_hi, n_lo, sel_rise, sel_low);
        total++; if (n_hi != TB_RST) begin bad++; $display("FAIL ign_prst_len got=%0d exp=%0d", n_hi, TB_RST); end
        total++; if (n_lo != TB_RUN) begin bad++; $display("FAIL ign_run_len got=%0d exp=%0d", n_lo, TB_RUN); end
        total++; if (sel_rise !== 1'b1) begin bad++; $display("FAIL ign_sel_rise got=%b exp=1", sel_rise); end
        for (int k = 1; k < TB_RDL; k++) begin
            start = 1'($urandom_range(0, 1));
            tick;
            total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL ign_fetch_valid got=%b exp=0", disp_valid); end
        end
        start = 1'($urandom_range(0, 1));
        tick;
        start = 1'b0;
        total++; if (disp_valid !== 1'b1 || disp_addr !== TB_FIRST || disp_data !== mem_word(TB_FIRST)) begin
            bad++; $display("FAIL ign_fetch_capture got=v%b a%0d d%h exp=v1 a%0d d%h", disp_valid, disp_addr, disp_data, TB_FIRST, mem_word(TB_FIRST));
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; step = 1'b0; auto_mode = 1'b0;
        for (int i = 0; i < TB_RDL; i++) pipe[i] = 10'd0;
        repeat (2) tick;
        rst = 1'b0;
        test_reset;
        test_run_window;
        test_manual;
        test_auto;
        test_rst_in_show;
        test_start_ignored;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
